// File: rtl/apb4_master_bridge_pkg.sv
// Shared types and constants for the APB4 master bridge.
package apb4_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_t;

  // Normal, secure, data access.
  localparam logic [2:0] PPROT_DEFAULT = 3'b000;

endpackage

// File: rtl/apb4_master_bridge.sv
// Single-outstanding APB4 initiator: one valid/ready request becomes one SETUP/ACCESS
// transfer, answered by one response; a bounded wait-state counter turns a hung slave into an error.
module apb4_master_bridge
  import apb4_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,   // 8, 16 or 32
  parameter int TIMEOUT    = 255   // 0 disables the timeout
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic                    req_write_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] req_strb_i,
  output logic                    rsp_valid_o,
  input  logic                    rsp_ready_i,
  output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
  output logic                    rsp_err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    pwrite_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  output logic [DATA_WIDTH/8-1:0] pstrb_o,
  output logic [2:0]              pprot_o,
  output logic                    psel_o,
  output logic                    penable_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [CW-1:0] CNT_SAT  = CW'((TIMEOUT > 0) ? TIMEOUT : 1);

  apb_state_t    state;
  logic [CW-1:0] wait_cnt;

  assign pprot_o = PPROT_DEFAULT;

  always_ff @(posedge pclk) begin
    if (preset) begin
      state       <= IDLE;
      req_ready_o <= 1'b1;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_err_o   <= 1'b0;
      rsp_rdata_o <= '0;
      paddr_o     <= '0;
      pwrite_o    <= 1'b0;
      pwdata_o    <= '0;
      pstrb_o     <= '0;
      wait_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            paddr_o     <= req_addr_i;
            pwrite_o    <= req_write_i;
            pwdata_o    <= req_wdata_i;
            pstrb_o     <= req_write_i ? req_strb_i : '0;
            wait_cnt    <= '0;
            req_ready_o <= 1'b0;
            psel_o      <= 1'b1;
            state       <= SETUP;
          end
        end

        SETUP: begin
          penable_o <= 1'b1;
          state     <= ACCESS;
        end

        ACCESS: begin
          if (!pready_i && wait_cnt != CNT_SAT)
            wait_cnt <= wait_cnt + 1'b1;
          // A completing slave wins over a timeout landing in the same cycle.
          if (pready_i) begin
            rsp_err_o   <= pslverr_i;
            rsp_rdata_o <= (!pwrite_o && !pslverr_i) ? prdata_i : '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end else if (TIMEOUT != 0 && wait_cnt == CNT_LAST) begin
            rsp_err_o   <= 1'b1;
            rsp_rdata_o <= '0;
            psel_o      <= 1'b0;
            penable_o   <= 1'b0;
            rsp_valid_o <= 1'b1;
            state       <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
            state       <= IDLE;
          end
        end

        default: begin
          psel_o      <= 1'b0;
          penable_o   <= 1'b0;
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb4_master_bridge.sv
// Table-driven bench with an APB slave model and a response scoreboard; TIMEOUT is set to 8.
module tb_apb4_master_bridge;

  localparam int TO = 8;

  logic        pclk = 1'b0;
  logic        preset;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] paddr, pwdata, prdata;
  logic        pwrite, psel, penable, pready, pslverr;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          ws;       // wait states before pready; >= TO never completes
    logic        slverr;
    logic [31:0] prdata;
    int          hold;     // cycles rsp_ready stays low in RESP
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  vec_t vecs[8];
  rsp_t sb[$];

  apb4_master_bridge #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .pclk(pclk), .preset(preset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_write_i(req_write),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_strb_i(req_strb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .paddr_o(paddr), .pwrite_o(pwrite), .pwdata_o(pwdata), .pstrb_o(pstrb),
    .pprot_o(pprot), .psel_o(psel), .penable_o(penable),
    .prdata_i(prdata), .pready_i(pready), .pslverr_i(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    logic [3:0] exp_strb;
    int         acc;
    int         unstable;
    bit         done;
    rsp_t       exp;
    exp_strb = v.write ? v.strb : 4'h0;

    req_write = v.write;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_strb  = v.strb;
    req_valid = 1'b1;
    rsp_ready = 1'b0;
    chk("req_ready_idle", req_ready, 1);
    step();
    req_valid = 1'b0;
    sb.push_back('{v.exp_rdata, v.exp_err});

    // SETUP: pready/pslverr asserted here must be ignored.
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_req_ready", req_ready, 0);
    chk("setup_paddr", paddr, v.addr);
    chk("setup_pstrb", pstrb, exp_strb);
    chk("pprot", pprot, 0);
    pready  = 1'b1;
    pslverr = 1'b1;
    step();
    pready  = 1'b0;
    pslverr = 1'b0;

    acc = 0;
    unstable = 0;
    done = 0;
    for (int k = 0; k < 40 && !done; k++) begin
      if (psel && penable) begin
        acc++;
        if (paddr !== v.addr || pstrb !== exp_strb || pwdata !== v.wdata || pwrite !== v.write)
          unstable++;
        pready  = (k == v.ws);
        pslverr = (k == v.ws) ? v.slverr : 1'b1;  // pslverr without pready is noise
        prdata  = (k == v.ws) ? v.prdata : 32'hFFFF_FFFF;
        step();
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 32'h0;
      end else begin
        done = 1;
      end
    end
    chk("access_cycles", acc, (v.ws >= TO) ? TO : v.ws + 1);
    chk("apb_stable", unstable, 0);
    chk("resp_psel", {psel, penable}, 0);

    for (int h = 0; h < v.hold; h++) begin
      chk("hold_rsp_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, v.exp_rdata);
      chk("hold_req_ready", req_ready, 0);
      chk("hold_psel", psel, 0);
      step();
    end

    rsp_ready = 1'b1;
    if (rsp_valid && sb.size() > 0) begin
      exp = sb.pop_front();
      chk("rsp_rdata", rsp_rdata, exp.rdata);
      chk("rsp_err", rsp_err, exp.err);
    end else begin
      checks++;
      errors++;
      $display("FAIL rsp_missing: rsp_valid %b, expected 1", rsp_valid);
      sb.delete();
    end
    step();
    rsp_ready = 1'b0;
    chk("post_rsp_valid", rsp_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    int seen;
    //         wr    addr          wdata         strb  ws  serr  prdata        hold exp_rdata     exp_err
    vecs[0] = '{1'b0, 32'h0000_0008, 32'h0,        4'hF, 0,  1'b0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, 3,  1'b0, 32'hAAAA_5555, 0, 32'h0,         1'b0};
    vecs[2] = '{1'b0, 32'h0000_0010, 32'h0,        4'hF, 1,  1'b1, 32'h0000_0055, 0, 32'h0,         1'b1};
    vecs[3] = '{1'b0, 32'h0000_0020, 32'h0,        4'hF, 99, 1'b0, 32'h0,         0, 32'h0,         1'b1};
    vecs[4] = '{1'b0, 32'h0000_0024, 32'h0,        4'h3, 0,  1'b0, 32'h0BAD_F00D, 5, 32'h0BAD_F00D, 1'b0};
    vecs[5] = '{1'b1, 32'h0000_0030, 32'hCAFE_0001, 4'h5, 2,  1'b1, 32'h1111_1111, 2, 32'h0,         1'b1};
    vecs[6] = '{1'b0, 32'h0000_0040, 32'h0,        4'hF, 7,  1'b0, 32'h7777_0007, 0, 32'h7777_0007, 1'b0};
    vecs[7] = '{1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'h8, 0,  1'b0, 32'h0,         1, 32'h0,         1'b0};

    preset = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_strb = '0;
    rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    step();
    step();
    preset = 1'b0;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_psel_penable", {psel, penable}, 0);
    chk("rst_rsp", {rsp_valid, rsp_err}, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pwdata", pwdata, 0);
    chk("rst_pstrb_pwrite", {pstrb, pwrite}, 0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset in the middle of ACCESS abandons the transfer silently.
    req_write = 1'b0; req_addr = 32'h0000_0050; req_strb = 4'hF; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    chk("mid_access", {psel, penable}, 2'b11);
    preset = 1'b1;
    step();
    preset = 1'b0;
    chk("mid_rst_psel", {psel, penable}, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    seen = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (rsp_valid || psel) seen++;
      step();
    end
    rsp_ready = 1'b0;
    chk("mid_rst_no_activity", seen, 0);
    chk("mid_rst_req_ready", req_ready, 1);

    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
